// File: rtl/parity_frame_tx.sv
// Serialiser for a data word plus its parity bit: start(0), data LSB-first, parity, stop(1).
// Optional input-parity checker enabled by defining PARITY_FRAME_TX_CHECK_EN.
module parity_frame_tx #(
  parameter int DATA_W       = 3,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              par_err
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_next;
  logic [DATA_W-1:0] data_q;
  logic              par_q;
  logic              bit_end;

  assign in_ready = (state == IDLE);
  assign bit_end  = (cnt == CNT_LAST);
  assign idx_next = idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      data_q <= '0;
      par_q  <= 1'b0;
      tx     <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (in_valid) begin
            data_q <= in_data;
            par_q  <= in_par;
            cnt    <= '0;
            idx    <= '0;
            state  <= START;
            tx     <= 1'b0;
            busy   <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= DATA;
            tx    <= data_q[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= PARITY;
              tx    <= par_q;
            end else begin
              idx <= idx_next;
              tx  <= data_q[idx_next];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // done lands in the first IDLE cycle, where in_ready is already high
          if (bit_end) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          idx   <= '0;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PARITY_FRAME_TX_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      par_err <= 1'b0;
    else if (in_valid && in_ready)
      par_err <= in_par ^ (^in_data);
  end
`else
  assign par_err = 1'b0;
`endif

endmodule
